ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 Parameter PC_WIDTH, default 32: address width. Parameter INSTR_WIDTH, default 32: instruction width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req_valid_o  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready_i  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr_o  output  PC_WIDTH  fetch address, word aligned.
REQ-008 imem_rsp_valid_i  input  1  instruction returned; in request order; never in the same cycle as its own request.
REQ-009 imem_rsp_instr_i  input  INSTR_WIDTH  returned instruction word.
REQ-010 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc_i  input  PC_WIDTH  new fetch address.
REQ-012 id_ready_i  input  1  decode stage accepts the presented instruction.
REQ-013 if_valid_o  output  1  if_instr_o/if_pc_o hold a valid instruction.
REQ-014 if_instr_o  output  INSTR_WIDTH  instruction to decode.
REQ-015 if_pc_o  output  PC_WIDTH  address of if_instr_o.

Function
REQ-016 State: fetch PC register (fpc); 2-entry in-order buffer of {pc, instr, filled}; outstanding counter out_cnt (0..2); discard counter drop_cnt (0..2).
REQ-017 imem_req_valid_o = 1 iff (out_cnt + buffer occupancy) < 2, redirect_i = 0 and rst = 0; imem_req_addr_o = fpc.
REQ-018 Request handshake: on imem_req_valid_o & imem_req_ready_i, allocate buffer entry {pc=fpc, filled=0}, out_cnt += 1, fpc += 4 (wraps modulo 2^PC_WIDTH).
REQ-019 imem_req_valid_o, once asserted, stays asserted with a stable address until accepted, unless redirect_i or rst.
REQ-020 Response: if drop_cnt > 0, discard word, drop_cnt -= 1; else fill oldest unfilled entry, out_cnt -= 1.
REQ-021 if_valid_o = head entry exists & filled & !redirect_i; if_pc_o/if_instr_o = head fields (registered; latency response->if_valid_o = 1 cycle).
REQ-022 Pop head on if_valid_o & id_ready_i; pop, new allocation and fill allowed in the same cycle.
REQ-023 Outputs stable while if_valid_o = 1 and id_ready_i = 0.
REQ-024 Redirect (redirect_i = 1): next cycle buffer empty, fpc = {redirect_pc_i[PC_WIDTH-1:2], 2'b00}, drop_cnt = out_cnt minus any response discarded/filled in that cycle, out_cnt = drop_cnt's new value counted separately (out_cnt = 0 for new stream).
REQ-025 New-stream requests may issue while drop_cnt > 0 if out_cnt + drop_cnt + occupancy < 2; responses always apply to drop_cnt first.
REQ-026 redirect_i has priority over pop, fill and request in the same cycle; a response arriving in the redirect cycle is discarded.
REQ-027 Back-to-back redirects: the later redirect_pc_i wins; no requests issue in either redirect cycle.

Reset
REQ-028 On rst: fpc = RESET_PC, buffer empty, out_cnt = 0, drop_cnt = 0; imem_req_valid_o = 0, if_valid_o = 0 during rst; if_instr_o/if_pc_o = 0.
REQ-029 rst mid-operation abandons all outstanding responses; responses arriving after rst deassertion with out_cnt = 0 are ignored.
REQ-030 First request: imem_req_valid_o = 1, addr = RESET_PC in the first cycle after rst deasserts.

Verification
REQ-031 Reset, ready=1, 1-cycle memory, id_ready=1 -> requests at 0x8000_0000, 0x8000_0004, ...; if_pc_o sequence matches; if_valid_o sustained 1/cycle after fill.
REQ-032 id_ready=0 for 5 cycles -> at most 2 requests accepted, if_valid_o=1 with pc 0x8000_0000 held; release -> 0x8000_0000, 0x8000_0004 in consecutive cycles.
REQ-033 Redirect to 0x8000_0102 with 2 outstanding -> next request addr 0x8000_0100; both old responses dropped; first if_pc_o = 0x8000_0100.
REQ-034 Redirect coincident with response and id_ready=1 -> response discarded, no pop observed (if_valid_o=0 that cycle), correct drop_cnt.
REQ-035 imem_req_ready_i=0 for 3 cycles -> addr stable, no fpc advance; rst asserted with 1 outstanding -> late response ignored, refetch from RESET_PC.
REQ-036 fpc = 32'hFFFF_FFFC sequential fetch -> next request addr 32'h0000_0000.

Source files
------------

// File: rtl/ifetch.sv
// ifetch -- instruction fetch front end.
//
// Sends word-aligned fetch requests to instruction memory and collects the
// in-order responses in a two-entry buffer. The buffer head is presented to
// decode. A redirect flushes the buffer, restarts fetch at the new target,
// and converts every response still owed by memory into a pending discard.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_req_valid_o    fetch request to instruction memory
//   imem_req_ready_i    memory accepts the request this cycle
//   imem_req_addr_o     fetch address (word aligned)
//   imem_rsp_valid_i    instruction returned, in request order
//   imem_rsp_instr_i    returned instruction word
//   redirect_i          taken branch/jump: flush and refetch
//   redirect_pc_i       new fetch address (low two bits ignored)
//   id_ready_i          decode accepts the presented instruction
//   if_valid_o          if_instr_o / if_pc_o hold a valid instruction
//   if_instr_o          instruction to decode
//   if_pc_o             address of if_instr_o
module ifetch #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid_o,
  input  logic                   imem_req_ready_i,
  output logic [PC_WIDTH-1:0]    imem_req_addr_o,
  input  logic                   imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_instr_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  input  logic                   id_ready_i,
  output logic                   if_valid_o,
  output logic [INSTR_WIDTH-1:0] if_instr_o,
  output logic [PC_WIDTH-1:0]    if_pc_o
);

  // Fetch PC and the two-entry in-order buffer. An entry is allocated when
  // its request is accepted and marked filled when its response returns.
  logic [PC_WIDTH-1:0]    r_fpc;
  logic [PC_WIDTH-1:0]    r_buf_pc    [2];
  logic [INSTR_WIDTH-1:0] r_buf_instr [2];
  logic [1:0]             r_buf_filled;
  logic                   r_head;
  logic [1:0]             r_count;

  // Responses still owed by memory: out_cnt for the live stream (each has an
  // unfilled buffer entry), drop_cnt for streams killed by redirect.
  logic [1:0]             r_out_cnt;
  logic [1:0]             r_drop_cnt;

  logic                   w_head_filled;
  logic                   w_next_filled;
  logic [2:0]             w_inflight;
  logic [2:0]             w_total;
  logic [1:0]             w_redir_drop;
  logic                   w_req_valid;
  logic                   w_req_fire;
  logic                   w_if_valid;
  logic                   w_pop;
  logic                   w_rsp_drop;
  logic                   w_rsp_fill;
  logic                   w_alloc_idx;
  logic                   w_fill_idx;
  logic                   w_unused;

  assign w_unused = &{1'b0, redirect_pc_i[1:0]};

  always_comb begin
    w_head_filled = (r_count != 2'd0) && r_buf_filled[r_head];
    w_next_filled = (r_count == 2'd2) && r_buf_filled[~r_head];

    // Unfilled entries are already represented by out_cnt, so only filled
    // entries add to the occupancy term. Counting drop_cnt as well keeps at
    // most two responses owed by memory across a redirect.
    w_inflight = {1'b0, r_out_cnt} + {1'b0, r_drop_cnt}
               + {2'b00, w_head_filled} + {2'b00, w_next_filled};

    // Depends only on registered state, redirect_i and rst, so once raised
    // it holds with a stable address until accepted.
    w_req_valid = !rst && !redirect_i && (w_inflight < 3'd2);
    w_req_fire  = w_req_valid && imem_req_ready_i;

    w_if_valid  = !rst && !redirect_i && w_head_filled;
    w_pop       = w_if_valid && id_ready_i;

    // Owed discards always absorb responses first; a response with nothing
    // owed (e.g. a leftover after reset) is ignored.
    w_rsp_drop  = imem_rsp_valid_i && (r_drop_cnt != 2'd0);
    w_rsp_fill  = imem_rsp_valid_i && (r_drop_cnt == 2'd0) && (r_out_cnt != 2'd0);

    w_alloc_idx = r_head ^ r_count[0];
    // Filled entries form a prefix of the buffer, so the oldest unfilled one
    // is the head unless the head already holds its instruction.
    w_fill_idx  = w_head_filled ? ~r_head : r_head;

    // On redirect everything still owed becomes a discard, less the response
    // (if any) arriving in the redirect cycle itself, which is thrown away.
    w_total      = {1'b0, r_out_cnt} + {1'b0, r_drop_cnt};
    w_redir_drop = w_total[1:0];
    if (imem_rsp_valid_i && (w_total != 3'd0)) begin
      w_redir_drop = 2'(w_total - 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc        <= RESET_PC;
      r_buf_filled <= 2'b00;
      r_head       <= 1'b0;
      r_count      <= 2'd0;
      r_out_cnt    <= 2'd0;
      r_drop_cnt   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_pc[i]    <= '0;
        r_buf_instr[i] <= '0;
      end
    end else if (redirect_i) begin
      r_fpc        <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
      r_buf_filled <= 2'b00;
      r_head       <= 1'b0;
      r_count      <= 2'd0;
      r_out_cnt    <= 2'd0;
      r_drop_cnt   <= w_redir_drop;
    end else begin
      if (w_req_fire) begin
        r_buf_pc[w_alloc_idx]     <= r_fpc;
        r_buf_filled[w_alloc_idx] <= 1'b0;
        r_fpc                     <= r_fpc + PC_WIDTH'(4);
      end
      if (w_rsp_fill) begin
        r_buf_instr[w_fill_idx]  <= imem_rsp_instr_i;
        r_buf_filled[w_fill_idx] <= 1'b1;
      end
      if (w_rsp_drop) begin
        r_drop_cnt <= r_drop_cnt - 2'd1;
      end
      r_out_cnt <= r_out_cnt + {1'b0, w_req_fire} - {1'b0, w_rsp_fill};
      r_count   <= r_count + {1'b0, w_req_fire} - {1'b0, w_pop};
      r_head    <= r_head ^ w_pop;
    end
  end

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_fpc;
  assign if_valid_o       = w_if_valid;
  // Head fields come straight from the buffer; forced to zero while in reset.
  assign if_pc_o          = rst ? '0 : r_buf_pc[r_head];
  assign if_instr_o       = rst ? '0 : r_buf_instr[r_head];

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;

  always #5 clk = ~clk;

  ifetch #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_instr_i (imem_rsp_instr_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_ready_i       (id_ready_i),
    .if_valid_o       (if_valid_o),
    .if_instr_o       (if_instr_o),
    .if_pc_o          (if_pc_o)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_req_acc = 0;
  int          snap;
  logic [31:0] exp_req;
  logic [31:0] sb_q[$];
  logic [31:0] mem_q[$];
  int          mem_due[$];
  int          pop_cyc[$];
  logic        mem_hold = 1'b0;
  int          mem_lat = 1;
  logic        auto_rdy = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Negedge: monitor handshakes, check deliveries against the scoreboard.
  task automatic sample();
    logic [31:0] e;
    @(negedge clk);
    if (redirect_i) begin
      chk("redir_no_req", 32'(imem_req_valid_o), 32'd0);
      chk("redir_no_valid", 32'(if_valid_o), 32'd0);
    end
    if (imem_req_valid_o && imem_req_ready_i) begin
      chk("req_addr", imem_req_addr_o, exp_req);
      exp_req = exp_req + 32'd4;
      n_req_acc++;
      mem_q.push_back(imem_req_addr_o);
      mem_due.push_back(cyc + mem_lat);
    end
    if (if_valid_o && id_ready_i) begin
      chk("pop_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("if_pc", if_pc_o, e);
        chk("if_instr", if_instr_o, mem_word(e));
        pop_cyc.push_back(cyc);
      end
    end
  endtask

  // Posedge + 1: drive the memory response and decode-ready for the new cycle.
  task automatic advance();
    logic [31:0] a;
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_instr_i = 32'd0;
    if (!mem_hold && mem_q.size() != 0 && cyc >= mem_due[0]) begin
      a = mem_q.pop_front();
      void'(mem_due.pop_front());
      imem_rsp_valid_i = 1'b1;
      imem_rsp_instr_i = mem_word(a);
    end
    id_ready_i = auto_rdy && (sb_q.size() != 0);
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
    id_ready_i = 1'b1;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < max_cyc) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_i    = 1'b1;
    redirect_pc_i = t;
    sb_q.delete();
    exp_req = {t[31:2], 2'b00};
    tick();
    redirect_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_instr_i = 32'd0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'd0;
    id_ready_i = 1'b0;
    exp_req = RST_PC;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
      chk("rst_if_valid", 32'(if_valid_o), 32'd0);
      chk("rst_if_pc", if_pc_o, 32'd0);
      chk("rst_if_instr", if_instr_o, 32'd0);
      advance();
    end
    rst = 1'b0;

    // Sequential fetch, 1-cycle memory, decode always ready
    push_stream(RST_PC, 8);
    sample();
    chk("first_req_valid", 32'(imem_req_valid_o), 32'd1);
    chk("first_req_addr", imem_req_addr_o, RST_PC);
    advance();
    drain("seq", 80);

    // Decode stall: head held stable, request count bounded by buffer depth
    auto_rdy = 1'b0;
    id_ready_i = 1'b0;
    snap = n_req_acc;
    ticks(5);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("hold_valid", 32'(if_valid_o), 32'd1);
      chk("hold_pc", if_pc_o, RST_PC + 32'h20);
      chk("hold_instr", if_instr_o, mem_word(RST_PC + 32'h20));
      advance();
    end
    chk("hold_reqs_le2", 32'((n_req_acc - snap) <= 2), 32'd1);
    auto_rdy = 1'b1;
    pop_cyc.delete();
    push_stream(RST_PC + 32'h20, 3);
    drain("release", 40);
    chk("release_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() >= 2) chk("release_b2b", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    ticks(5);

    // Redirect with two responses outstanding
    mem_hold = 1'b1;
    do_redirect(32'h9000_0000);
    snap = n_req_acc;
    ticks(3);
    chk("two_outstanding", 32'(n_req_acc - snap), 32'd2);
    do_redirect(32'h8000_0102);
    mem_hold = 1'b0;
    push_stream(32'h8000_0100, 4);
    drain("redir", 60);
    ticks(5);

    // Redirect coincident with a response while head valid and decode ready
    mem_hold = 1'b1;
    do_redirect(32'h8000_0400);
    ticks(3);
    mem_hold = 1'b0;
    tick();
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0500;
    sb_q.delete();
    exp_req = 32'h8000_0500;
    push_stream(32'h8000_0500, 3);
    sample();
    chk("coincident_no_pop", 32'(if_valid_o), 32'd0);
    advance();
    redirect_i = 1'b0;
    drain("coincident", 60);
    ticks(5);

    // Back-to-back redirects, then memory not ready for 3 cycles
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0700;
    sb_q.delete();
    tick();
    redirect_pc_i = 32'h8000_0600;
    tick();
    redirect_i = 1'b0;
    exp_req = 32'h8000_0600;
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stall_valid", 32'(imem_req_valid_o), 32'd1);
      chk("stall_addr", imem_req_addr_o, 32'h8000_0600);
      advance();
    end
    mem_hold = 1'b1;
    imem_req_ready_i = 1'b1;
    snap = n_req_acc;
    tick();
    imem_req_ready_i = 1'b0;
    chk("one_outstanding", 32'(n_req_acc - snap), 32'd1);

    // Reset with one response outstanding; late response must be ignored
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst2_req_valid", 32'(imem_req_valid_o), 32'd0);
      chk("rst2_if_valid", 32'(if_valid_o), 32'd0);
      advance();
    end
    rst = 1'b0;
    mem_hold = 1'b0;
    exp_req = RST_PC;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("late_rsp_ignored", 32'(if_valid_o), 32'd0);
      chk("post_rst_req", 32'(imem_req_valid_o), 32'd1);
      chk("post_rst_addr", imem_req_addr_o, RST_PC);
      advance();
    end
    chk("late_rsp_delivered", 32'(mem_q.size()), 32'd0);
    imem_req_ready_i = 1'b1;
    push_stream(RST_PC, 4);
    drain("refetch", 60);
    ticks(5);

    // Address wrap at the top of the address space
    do_redirect(32'hFFFF_FFFC);
    push_stream(32'hFFFF_FFFC, 4);
    drain("wrap", 60);
    ticks(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
